mem_access_ctrl: RTL

- Initiator-side sequencer that drives the data memory's addr/inputd/write/read strobes on behalf of the CPU core.
- Accepts single or burst (1..16 word) read/write requests over valid/ready handshakes.
- Streams read words out and write words in, one memory strobe per beat.
- Sits between the core's load/store path and the data memory; the memory samples strobes on the falling clock edge.

---
 rtl/mem_access_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Initiator-side sequencer that turns single or burst (req_len+1 words)
// read/write requests from the core into one memory strobe per beat.
// The data memory samples mem_addr/mem_wdata/mem_write/mem_read on the
// falling edge of clk, so every strobe is decoded from registered state.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (accepted only in IDLE)
//   req_write/req_addr/req_len  op, start word address, word count minus one
//   wr_valid/wr_ready/wr_data   write data beat handshake
//   rd_valid/rd_ready/rd_data   read data beat handshake
//   rd_last                     last beat of a read burst (qualified by rd_valid)
//   busy                        burst in progress
//   err                         sticky out-of-range flag (0 unless bounds check built)
//   mem_addr/mem_wdata          memory address and write data
//   mem_write/mem_read          memory strobes, never both high
//   mem_rdata                   memory read data
//
// Build option: define MEMCTL_BOUNDS_CHECK_EN to suppress strobes for
// addresses >= DEPTH and flag them on err.
module mem_access_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef MEMCTL_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, WDATA, WRITE, READ, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_last_q, rd_last_d;
  logic                err_q, err_d;
  logic                oob;

  // Out-of-range test on the registered address; constant 0 when the
  // bounds check is not built, so addresses alias in the memory.
  assign oob = BOUNDS_EN && ({1'b0, addr_q} >= DEPTH_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          cnt_d   = req_len;
          err_d   = 1'b0;
          state_d = req_write ? WDATA : READ;
        end
      end
      WDATA: begin
        if (wr_valid) begin
          wdata_d = wr_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (oob) err_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = WDATA;
        end
      end
      READ: begin
        // Memory drove mem_rdata on this cycle's falling edge.
        rd_data_d  = oob ? '0 : mem_rdata;
        rd_valid_d = 1'b1;
        rd_last_d  = (cnt_q == '0);
        if (oob) err_d = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          if (rd_last_q) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == WDATA);
  assign busy      = (state_q != IDLE);
  assign mem_write = (state_q == WRITE) && !oob;
  assign mem_read  = (state_q == READ) && !oob;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign err       = BOUNDS_EN && err_q;

endmodule
